// File: rtl/bnn_act_feeder_if.sv
// MAC-side stream of the activation feeder: beat data/valid/ready towards the
// binary MAC, plus the MAC's result/done returned to the feeder.
interface bnn_act_feeder_if #(
  parameter int unsigned LANES = 3,
  parameter int unsigned DW    = 2
);
  logic [LANES*DW-1:0] mac_in;
  logic                mac_valid;
  logic                mac_ready;
  logic [DW-1:0]       mac_out;
  logic                mac_done;

  modport master (output mac_in, mac_valid, input mac_ready, mac_out, mac_done);
  modport slave  (input mac_in, mac_valid, output mac_ready, mac_out, mac_done);
endinterface

// File: rtl/bnn_act_feeder.sv
// Buffers one frame of N_ELEM bipolar activations, streams it LANES per beat to
// the MAC, then captures the MAC result. Define FEEDER_TIMEOUT_EN to bound WAIT.
module bnn_act_feeder #(
  parameter int unsigned N_ELEM  = 108,
  parameter int unsigned LANES   = 3,
  parameter int unsigned DW      = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DW-1:0]        wr_data,
  output logic                 wr_ready,
  input  logic                 start,
  bnn_act_feeder_if.master     mac,
  output logic [DW-1:0]        result,
  output logic                 done,
  output logic                 busy,
  output logic                 bad_code,
  output logic                 timeout_err
);

  localparam int unsigned N_BEATS = (N_ELEM + LANES - 1) / LANES;
  localparam int unsigned PW      = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int unsigned BUS_W   = LANES * DW;
  localparam logic [DW-1:0] CODE_BAD = DW'(2);

  typedef enum logic [1:0] {S_LOAD, S_FULL, S_STREAM, S_WAIT} state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     beat_sel;
  logic [BUS_W-1:0]  beat_data;
  logic              tmo_expire;
  logic [DW-1:0]     mem [N_ELEM];

  // Frame storage; illegal code 10 is stored as padding
  always_ff @(posedge clk) begin
    if (state == S_LOAD && wr_en) begin
      mem[wr_ptr] <= (wr_data == CODE_BAD) ? '0 : wr_data;
    end
  end

  // Data for the beat that will be presented next (beat 0 when leaving FULL)
  always_comb begin
    beat_sel  = (state == S_FULL) ? '0 : beat + BW'(1);
    beat_data = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (32'(beat_sel) * LANES + j < N_ELEM) begin
        beat_data[(LANES-j)*DW-1 -: DW] = mem[PW'(32'(beat_sel) * LANES + j)];
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_LOAD;
      wr_ptr        <= '0;
      beat          <= '0;
      wr_ready      <= 1'b1;
      mac.mac_in    <= '0;
      mac.mac_valid <= 1'b0;
      result        <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      bad_code      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD: begin
          if (wr_en) begin
            if (wr_data == CODE_BAD) bad_code <= 1'b1;
            if (wr_ptr == PW'(N_ELEM - 1)) begin
              state    <= S_FULL;
              wr_ptr   <= '0;
              wr_ready <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        S_FULL: begin
          if (start) begin
            state         <= S_STREAM;
            beat          <= '0;
            busy          <= 1'b1;
            mac.mac_valid <= 1'b1;
            mac.mac_in    <= beat_data;
          end
        end
        S_STREAM: begin
          if (mac.mac_ready) begin
            if (beat == BW'(N_BEATS - 1)) begin
              state         <= S_WAIT;
              mac.mac_valid <= 1'b0;
              mac.mac_in    <= '0;
            end else begin
              beat       <= beat + BW'(1);
              mac.mac_in <= beat_data;
            end
          end
        end
        S_WAIT: begin
          // A result arriving on the expiry cycle takes priority over the timeout
          if (mac.mac_done) begin
            state    <= S_LOAD;
            result   <= mac.mac_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end else if (tmo_expire) begin
            state    <= S_LOAD;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_expire = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));

  // WAIT watchdog; counts cycles spent waiting for the MAC result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_WAIT && !mac.mac_done) tmo_cnt <= tmo_cnt + TW'(1);
      else                                  tmo_cnt <= '0;
      if (tmo_expire && !mac.mac_done) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_expire  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_act_feeder.sv
// Self-checking bench for bnn_act_feeder: frame streaming, padding, backpressure,
// illegal codes, protocol guards, mid-frame reset and the optional WAIT timeout.
module tb_bnn_act_feeder;

  localparam int unsigned N   = 108;
  localparam int unsigned L   = 3;
  localparam int unsigned DW  = 2;
  localparam int unsigned NB  = (N + L - 1) / L;
  localparam int unsigned N7  = 7;

  logic clk = 1'b0;
  logic rst;
  logic wr_en, start, wr_ready, done, busy, bad_code, timeout_err;
  logic [DW-1:0] wr_data, result;
  logic p_wr_en, p_start, p_wr_ready, p_done, p_busy, p_bad_code, p_timeout_err;
  logic [DW-1:0] p_wr_data, p_result;

  int checks = 0;
  int errors = 0;

  bnn_act_feeder_if #(.LANES(L), .DW(DW)) mac_if ();
  bnn_act_feeder_if #(.LANES(L), .DW(DW)) mac7 ();

  bnn_act_feeder #(.N_ELEM(N), .LANES(L), .DW(DW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .mac(mac_if), .result(result), .done(done), .busy(busy),
    .bad_code(bad_code), .timeout_err(timeout_err)
  );

  bnn_act_feeder #(.N_ELEM(N7), .LANES(L), .DW(DW), .TIMEOUT(64)) dut7 (
    .clk(clk), .rst(rst), .wr_en(p_wr_en), .wr_data(p_wr_data), .wr_ready(p_wr_ready),
    .start(p_start), .mac(mac7), .result(p_result), .done(p_done), .busy(p_busy),
    .bad_code(p_bad_code), .timeout_err(p_timeout_err)
  );

  always #5 clk = ~clk;

  // Reference: beat b carries elements b*L .. b*L+L-1, lane 0 in the MS bits,
  // missing elements and illegal codes read as 00
  function automatic logic [L*DW-1:0] model_beat(input logic [1:0] fr[$], input int b);
    logic [L*DW-1:0] r;
    r = '0;
    for (int j = 0; j < int'(L); j++) begin
      int idx;
      logic [1:0] v;
      idx = b * int'(L) + j;
      v = (idx < fr.size()) ? fr[idx] : 2'b00;
      if (v == 2'b10) v = 2'b00;
      r[(int'(L)-j)*2-1 -: 2] = v;
    end
    return r;
  endfunction

  function automatic logic [1:0] rand_elem();
    case ($urandom_range(0, 2))
      0:       return 2'b01;
      1:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic write_frame(input logic [1:0] fr[$], input bit start_last);
    for (int i = 0; i < fr.size(); i++) begin
      @(negedge clk);
      if (i == fr.size() - 1) begin
        checks++;
        if (wr_ready !== 1'b1) begin
          errors++; $display("FAIL wr_ready_before_last: got %b want 1", wr_ready);
        end
      end
      wr_en   = 1'b1;
      wr_data = fr[i];
      start   = start_last && (i == fr.size() - 1);
    end
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++; $display("FAIL wr_ready_full: got %b want 0", wr_ready);
    end
    if (start_last) begin
      checks++;
      if (mac_if.mac_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL start_on_final_write: valid=%b busy=%b want 0 0", mac_if.mac_valid, busy);
      end
    end
  endtask

  // mode 0: ready high, 1: ready toggling, 2: random ready. guard drives wr_en
  // and mac_done during the stream. abort_at >= 0 returns once that beat is shown.
  task automatic stream_collect(input logic [1:0] fr[$], input int mode, input bit guard, input int abort_at);
    int acc = 0;
    int cyc = 0;
    int fails = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (acc < int'(NB) && cyc < 2000 && fails < 5) begin
      checks++;
      if (mac_if.mac_valid !== 1'b1) begin
        errors++; fails++; $display("FAIL stream_valid beat %0d: got %b want 1", acc, mac_if.mac_valid);
      end
      checks++;
      if (mac_if.mac_in !== model_beat(fr, acc)) begin
        errors++; fails++; $display("FAIL stream_data beat %0d: got %b want %b", acc, mac_if.mac_in, model_beat(fr, acc));
      end
      if (guard) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++; fails++; $display("FAIL guard_stream beat %0d: done=%b busy=%b want 0 1", acc, done, busy);
        end
      end
      if (abort_at >= 0 && acc == abort_at) return;
      case (mode)
        0:       mac_if.mac_ready = 1'b1;
        1:       mac_if.mac_ready = cyc[0];
        default: mac_if.mac_ready = 1'($urandom_range(0, 1));
      endcase
      if (guard) begin
        wr_en = 1'b1; wr_data = rand_elem();
        mac_if.mac_done = 1'b1; mac_if.mac_out = 2'b10;
      end
      if (mac_if.mac_valid === 1'b1 && mac_if.mac_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    mac_if.mac_ready = 1'b0;
    mac_if.mac_done  = 1'b0;
    wr_en = 1'b0;
    if (acc < int'(NB)) begin
      checks++; errors++;
      $display("FAIL stream_budget: accepted %0d beats want %0d", acc, NB);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != int'(NB)) begin
        errors++; $display("FAIL stream_cycles: got %0d want %0d", cyc, NB);
      end
    end
    checks++;
    if (mac_if.mac_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL enter_wait: valid=%b busy=%b want 0 1", mac_if.mac_valid, busy);
    end
  endtask

  task automatic finish_mac(input logic [1:0] out);
    @(negedge clk);
    mac_if.mac_done = 1'b1;
    mac_if.mac_out  = out;
    @(negedge clk);
    mac_if.mac_done = 1'b0;
    mac_if.mac_out  = 2'b00;
    checks++;
    if (result !== out) begin
      errors++; $display("FAIL result: got %b want %b", result, out);
    end
    checks++;
    if ({done, busy, wr_ready} !== 3'b101) begin
      errors++; $display("FAIL done_cycle: done/busy/wr_ready=%b want 101", {done, busy, wr_ready});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got %b want 0", done);
    end
  endtask

  function automatic void check_reset_values(input string tag);
    checks++;
    if ({wr_ready, mac_if.mac_valid, mac_if.mac_in, result, done, busy, bad_code, timeout_err} !== {1'b1, 1'b0, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: wr_ready=%b valid=%b mac_in=%b result=%b done=%b busy=%b bad=%b tmo=%b want 1 0 000000 00 0 0 0 0",
               tag, wr_ready, mac_if.mac_valid, mac_if.mac_in, result, done, busy, bad_code, timeout_err);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 0; wr_data = 0; start = 0;
    mac_if.mac_ready = 0; mac_if.mac_done = 0; mac_if.mac_out = 0;
    p_wr_en = 0; p_wr_data = 0; p_start = 0;
    mac7.mac_ready = 0; mac7.mac_done = 0; mac7.mac_out = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_values");
    checks++;
    if ({p_wr_ready, mac7.mac_valid, p_busy} !== 3'b100) begin
      errors++; $display("FAIL reset_dut7: got %b want 100", {p_wr_ready, mac7.mac_valid, p_busy});
    end
  endtask

  task automatic test_frame_order();
    logic [1:0] fr[$];
    for (int i = 0; i < int'(N); i++) fr.push_back((i % 2 == 1) ? 2'b11 : 2'b01);
    write_frame(fr, 1'b0);
    stream_collect(fr, 0, 1'b0, -1);
    finish_mac(2'b11);
  endtask

  task automatic test_padding();
    logic [5:0] exp;
    for (int i = 0; i < int'(N7); i++) begin
      @(negedge clk);
      p_wr_en = 1'b1; p_wr_data = 2'b01;
    end
    @(negedge clk);
    p_wr_en = 1'b0;
    checks++;
    if (p_wr_ready !== 1'b0) begin
      errors++; $display("FAIL pad_full: got %b want 0", p_wr_ready);
    end
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mac7.mac_ready = 1'b1;
      exp = (b == 2) ? 6'b01_00_00 : 6'b01_01_01;
      checks++;
      if (mac7.mac_valid !== 1'b1 || mac7.mac_in !== exp) begin
        errors++; $display("FAIL pad_beat %0d: valid=%b data=%b want 1 %b", b, mac7.mac_valid, mac7.mac_in, exp);
      end
      @(negedge clk);
    end
    mac7.mac_ready = 1'b0;
    checks++;
    if (mac7.mac_valid !== 1'b0 || p_busy !== 1'b1) begin
      errors++; $display("FAIL pad_end: valid=%b busy=%b want 0 1", mac7.mac_valid, p_busy);
    end
    mac7.mac_done = 1'b1; mac7.mac_out = 2'b01;
    @(negedge clk);
    mac7.mac_done = 1'b0;
    checks++;
    if (p_result !== 2'b01 || p_done !== 1'b1) begin
      errors++; $display("FAIL pad_result: result=%b done=%b want 01 1", p_result, p_done);
    end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      logic [1:0] fr[$];
      for (int i = 0; i < int'(N); i++) fr.push_back(rand_elem());
      write_frame(fr, 1'b0);
      stream_collect(fr, m, 1'b0, -1);
      finish_mac(rand_elem());
    end
  endtask

  task automatic test_bad_code();
    logic [1:0] fr[$];
    for (int i = 0; i < int'(N); i++) fr.push_back(rand_elem());
    fr[0] = 2'b01; fr[1] = 2'b01; fr[5] = 2'b10;
    write_frame(fr, 1'b0);
    checks++;
    if (bad_code !== 1'b1) begin
      errors++; $display("FAIL bad_code_set: got %b want 1", bad_code);
    end
    stream_collect(fr, 2, 1'b0, -1);
    finish_mac(2'b01);
  endtask

  task automatic test_guards();
    logic [1:0] fr[$];
    checks++;
    if (bad_code !== 1'b1) begin
      errors++; $display("FAIL bad_code_sticky: got %b want 1", bad_code);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({mac_if.mac_valid, busy, wr_ready} !== 3'b001) begin
      errors++; $display("FAIL start_in_load: valid/busy/wr_ready=%b want 001", {mac_if.mac_valid, busy, wr_ready});
    end
    for (int i = 0; i < int'(N); i++) fr.push_back(rand_elem());
    write_frame(fr, 1'b0);
    stream_collect(fr, 0, 1'b1, -1);
    finish_mac(2'b00);
  endtask

  task automatic test_start_on_final_write();
    logic [1:0] fr[$];
    for (int i = 0; i < int'(N); i++) fr.push_back(rand_elem());
    write_frame(fr, 1'b1);
    stream_collect(fr, 0, 1'b0, -1);
    finish_mac(2'b11);
  endtask

  task automatic test_timeout();
    logic [1:0] fr[$];
    for (int i = 0; i < int'(N); i++) fr.push_back(rand_elem());
    write_frame(fr, 1'b0);
    stream_collect(fr, 0, 1'b0, -1);
`ifdef FEEDER_TIMEOUT_EN
    for (int k = 2; k <= 65; k++) begin
      @(negedge clk);
      if (k == 64) begin
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL timeout_early: tmo=%b busy=%b want 0 1", timeout_err, busy);
        end
      end
    end
    checks++;
    if ({timeout_err, done, busy, wr_ready} !== 4'b1001) begin
      errors++; $display("FAIL timeout_expire: tmo/done/busy/wr_ready=%b want 1001", {timeout_err, done, busy, wr_ready});
    end
`else
    repeat (100) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wait_forever: tmo=%b busy=%b want 0 1", timeout_err, busy);
    end
    finish_mac(2'b01);
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] fr[$];
    logic [1:0] fr2[$];
    for (int i = 0; i < int'(N); i++) fr.push_back(rand_elem());
    write_frame(fr, 1'b0);
    stream_collect(fr, 0, 1'b0, 20);
    #2 rst = 1'b1;
    #1 check_reset_values("reset_mid_async");
    mac_if.mac_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid_after");
    for (int i = 0; i < int'(N); i++) fr2.push_back(rand_elem());
    write_frame(fr2, 1'b0);
    stream_collect(fr2, 0, 1'b0, -1);
    finish_mac(2'b11);
  endtask

  initial begin
    test_reset();
    test_frame_order();
    test_padding();
    test_backpressure();
    test_bad_code();
    test_guards();
    test_start_on_final_write();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
